// File: rtl/hist_pkg.sv
// Shared types and default widths for the histogramming core and its readout stages.
package hist_pkg;

  localparam int unsigned BinWDef = 8;
  localparam int unsigned IdxWDef = 8;
  localparam int unsigned SumWDef = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

endpackage

// File: rtl/hist_peak_finder_if.sv
// Bin-count readout stream: one count per beat, last marks the final bin of a frame.
interface hist_peak_finder_if #(
  parameter int unsigned BIN_W = 8
);
  logic [BIN_W-1:0] bin_data;
  logic             bin_valid;
  logic             bin_last;

  modport master (output bin_data, output bin_valid, output bin_last);
  modport slave  (input  bin_data, input  bin_valid, input  bin_last);
endinterface

// File: rtl/sat_accum.sv
// Saturating accumulator with a sticky saturate flag; exposes next-state values so the
// caller can publish the sum including the beat being accepted.
module sat_accum #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic [IN_W-1:0]  addend,
  output logic [SUM_W-1:0] sum,
  output logic             sat,
  output logic [SUM_W-1:0] sum_nxt,
  output logic             sat_nxt
);

  localparam int unsigned W = ((SUM_W > IN_W) ? SUM_W : IN_W) + 1;

  logic [SUM_W-1:0] sum_q, sum_d, base;
  logic             sat_q, sat_d, base_sat;
  logic [W-1:0]     wide;

  always_comb begin
    base     = start ? '0 : sum_q;
    base_sat = start ? 1'b0 : sat_q;
    wide     = W'(base) + W'(addend);
    sum_nxt  = base;
    sat_nxt  = base_sat;
    if (en) begin
      if (|wide[W-1:SUM_W]) begin
        sum_nxt = '1;
        sat_nxt = 1'b1;
      end else begin
        sum_nxt = wide[SUM_W-1:0];
      end
    end
    sum_d = sum_q;
    sat_d = sat_q;
    if (clr) begin
      sum_d = '0;
      sat_d = 1'b0;
    end else if (en || start) begin
      sum_d = sum_nxt;
      sat_d = sat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      sat_q <= sat_d;
    end
  end

  assign sum = sum_q;
  assign sat = sat_q;

endmodule

// File: rtl/hist_peak_finder.sv
// Reduces each histogram readout frame to peak, nonzero span, saturating total and beat count.
// Results are held until the next frame publishes.
module hist_peak_finder
  import hist_pkg::*;
#(
  parameter int unsigned BIN_W = BinWDef,
  parameter int unsigned IDX_W = IdxWDef,
  parameter int unsigned SUM_W = SumWDef
) (
  input  logic               clk,
  input  logic               rst_n,
  hist_peak_finder_if.slave  bin_if,
  input  logic               clear,
  output logic [IDX_W-1:0]   peak_idx,
  output logic [BIN_W-1:0]   peak_cnt,
  output logic [IDX_W-1:0]   first_nz,
  output logic [IDX_W-1:0]   last_nz,
  output logic               empty,
  output logic [SUM_W-1:0]   total,
  output logic               total_sat,
  output logic [IDX_W:0]     nbins,
  output logic               frame_err,
  output logic               result_valid,
  output logic               busy
);

  state_e state_q, state_d;

  // Working registers for the frame in progress
  logic [IDX_W:0]   nbins_q, nbins_d;
  logic [IDX_W-1:0] pk_idx_q, pk_idx_d, fnz_q, fnz_d, lnz_q, lnz_d;
  logic [BIN_W-1:0] pk_cnt_q, pk_cnt_d;
  logic             seen_q, seen_d, err_q, err_d;

  // Published results
  logic [IDX_W:0]   r_nbins_q, r_nbins_d;
  logic [IDX_W-1:0] r_pk_idx_q, r_pk_idx_d, r_fnz_q, r_fnz_d, r_lnz_q, r_lnz_d;
  logic [BIN_W-1:0] r_pk_cnt_q, r_pk_cnt_d;
  logic [SUM_W-1:0] r_total_q, r_total_d;
  logic             r_empty_q, r_empty_d, r_sat_q, r_sat_d, r_err_q, r_err_d;
  logic             r_valid_q, r_valid_d;

  logic [BIN_W-1:0] data;
  logic             accept, start, overflow, counted, publish;
  logic [IDX_W-1:0] cur_idx;
  logic [SUM_W-1:0] sum_cur, sum_nxt;
  logic             sat_cur, sat_nxt;

  assign data     = bin_if.bin_data;
  assign accept   = bin_if.bin_valid && !clear;
  assign start    = accept && (state_q != StAccum);
  // Index space exhausted: beat is flagged but not folded into the statistics
  assign overflow = accept && !start && nbins_q[IDX_W];
  assign counted  = accept && !overflow;
  assign publish  = accept && bin_if.bin_last;
  assign cur_idx  = start ? '0 : nbins_q[IDX_W-1:0];

  sat_accum #(
    .IN_W (BIN_W),
    .SUM_W(SUM_W)
  ) u_total (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clear),
    .start  (start),
    .en     (counted),
    .addend (data),
    .sum    (sum_cur),
    .sat    (sat_cur),
    .sum_nxt(sum_nxt),
    .sat_nxt(sat_nxt)
  );

  always_comb begin
    state_d  = state_q;
    nbins_d  = nbins_q;
    pk_idx_d = pk_idx_q;
    pk_cnt_d = pk_cnt_q;
    fnz_d    = fnz_q;
    lnz_d    = lnz_q;
    seen_d   = seen_q;
    err_d    = err_q;

    if (accept) begin
      if (start) begin
        nbins_d  = '0;
        pk_idx_d = '0;
        pk_cnt_d = '0;
        fnz_d    = '0;
        lnz_d    = '0;
        seen_d   = 1'b0;
        err_d    = 1'b0;
      end
      err_d = err_d | overflow;
      if (counted) begin
        nbins_d = nbins_d + {{IDX_W{1'b0}}, 1'b1};
        if (data > pk_cnt_d) begin
          pk_cnt_d = data;
          pk_idx_d = cur_idx;
        end
        if (data != '0) begin
          if (!seen_d) fnz_d = cur_idx;
          lnz_d  = cur_idx;
          seen_d = 1'b1;
        end
      end
      state_d = bin_if.bin_last ? StDone : StAccum;
    end

    if (clear) begin
      state_d  = StIdle;
      nbins_d  = '0;
      pk_idx_d = '0;
      pk_cnt_d = '0;
      fnz_d    = '0;
      lnz_d    = '0;
      seen_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_comb begin
    r_nbins_d  = r_nbins_q;
    r_pk_idx_d = r_pk_idx_q;
    r_pk_cnt_d = r_pk_cnt_q;
    r_fnz_d    = r_fnz_q;
    r_lnz_d    = r_lnz_q;
    r_total_d  = r_total_q;
    r_empty_d  = r_empty_q;
    r_sat_d    = r_sat_q;
    r_err_d    = r_err_q;
    r_valid_d  = r_valid_q;

    if (clear) begin
      r_nbins_d  = '0;
      r_pk_idx_d = '0;
      r_pk_cnt_d = '0;
      r_fnz_d    = '0;
      r_lnz_d    = '0;
      r_total_d  = '0;
      r_empty_d  = 1'b0;
      r_sat_d    = 1'b0;
      r_err_d    = 1'b0;
      r_valid_d  = 1'b0;
    end else if (publish) begin
      r_nbins_d  = nbins_d;
      r_pk_idx_d = pk_idx_d;
      r_pk_cnt_d = pk_cnt_d;
      r_fnz_d    = fnz_d;
      r_lnz_d    = lnz_d;
      r_total_d  = sum_nxt;
      r_empty_d  = !seen_d;
      r_sat_d    = sat_nxt;
      r_err_d    = err_d;
      r_valid_d  = 1'b1;
    end else if (start) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      nbins_q    <= '0;
      pk_idx_q   <= '0;
      pk_cnt_q   <= '0;
      fnz_q      <= '0;
      lnz_q      <= '0;
      seen_q     <= 1'b0;
      err_q      <= 1'b0;
      r_nbins_q  <= '0;
      r_pk_idx_q <= '0;
      r_pk_cnt_q <= '0;
      r_fnz_q    <= '0;
      r_lnz_q    <= '0;
      r_total_q  <= '0;
      r_empty_q  <= 1'b0;
      r_sat_q    <= 1'b0;
      r_err_q    <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nbins_q    <= nbins_d;
      pk_idx_q   <= pk_idx_d;
      pk_cnt_q   <= pk_cnt_d;
      fnz_q      <= fnz_d;
      lnz_q      <= lnz_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      r_nbins_q  <= r_nbins_d;
      r_pk_idx_q <= r_pk_idx_d;
      r_pk_cnt_q <= r_pk_cnt_d;
      r_fnz_q    <= r_fnz_d;
      r_lnz_q    <= r_lnz_d;
      r_total_q  <= r_total_d;
      r_empty_q  <= r_empty_d;
      r_sat_q    <= r_sat_d;
      r_err_q    <= r_err_d;
      r_valid_q  <= r_valid_d;
    end
  end

  assign peak_idx     = r_pk_idx_q;
  assign peak_cnt     = r_pk_cnt_q;
  assign first_nz     = r_fnz_q;
  assign last_nz      = r_lnz_q;
  assign empty        = r_empty_q;
  assign total        = r_total_q;
  assign total_sat    = r_sat_q;
  assign nbins        = r_nbins_q;
  assign frame_err    = r_err_q;
  assign result_valid = r_valid_q;
  assign busy         = (state_q == StAccum);

endmodule

// File: tb/tb_hist_peak_finder.sv
// Directed bench: default instance plus narrow-total and narrow-index instances.
module tb_hist_peak_finder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  hist_peak_finder_if #(.BIN_W(8)) if0 ();
  hist_peak_finder_if #(.BIN_W(8)) if1 ();
  hist_peak_finder_if #(.BIN_W(8)) if2 ();
  logic clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;

  logic [7:0]  pi0, pc0, f0, l0;
  logic [15:0] tot0;
  logic [8:0]  nb0;
  logic        e0, s0, fe0, rv0, b0;

  logic [7:0]  pi1, pc1, f1, l1;
  logic [9:0]  tot1;
  logic [8:0]  nb1;
  logic        e1, s1, fe1, rv1, b1;

  logic [1:0]  pi2, f2, l2;
  logic [7:0]  pc2;
  logic [15:0] tot2;
  logic [2:0]  nb2;
  logic        e2, s2, fe2, rv2, b2;

  hist_peak_finder dut0 (
    .clk(clk), .rst_n(rst_n), .bin_if(if0.slave), .clear(clr0),
    .peak_idx(pi0), .peak_cnt(pc0), .first_nz(f0), .last_nz(l0), .empty(e0),
    .total(tot0), .total_sat(s0), .nbins(nb0), .frame_err(fe0),
    .result_valid(rv0), .busy(b0)
  );

  hist_peak_finder #(.SUM_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .bin_if(if1.slave), .clear(clr1),
    .peak_idx(pi1), .peak_cnt(pc1), .first_nz(f1), .last_nz(l1), .empty(e1),
    .total(tot1), .total_sat(s1), .nbins(nb1), .frame_err(fe1),
    .result_valid(rv1), .busy(b1)
  );

  hist_peak_finder #(.IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bin_if(if2.slave), .clear(clr2),
    .peak_idx(pi2), .peak_cnt(pc2), .first_nz(f2), .last_nz(l2), .empty(e2),
    .total(tot2), .total_sat(s2), .nbins(nb2), .frame_err(fe2),
    .result_valid(rv2), .busy(b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    case (sel)
      0: begin if0.bin_valid = v; if0.bin_data = d; if0.bin_last = l; end
      1: begin if1.bin_valid = v; if1.bin_data = d; if1.bin_last = l; end
      default: begin if2.bin_valid = v; if2.bin_data = d; if2.bin_last = l; end
    endcase
  endtask

  // One beat, then inputs idle; outputs are sampled 1 time unit after the edge
  task automatic send(input int sel, input logic [7:0] d, input logic l);
    drive(sel, 1'b1, d, l);
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'd0, 1'b0);
    idle(2);
    chk("reset_rv", rv0, 0);
    chk("reset_busy", b0, 0);
    chk("reset_peak_cnt", pc0, 0);
    chk("reset_total", tot0, 0);
    rst_n = 1'b1;
    idle(1);

    // {3,9,9,1}
    send(0, 8'd3, 1'b0);
    chk("a_busy_start", b0, 1);
    chk("a_rv_start", rv0, 0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd1, 1'b1);
    chk("a_peak_idx", pi0, 1);
    chk("a_peak_cnt", pc0, 9);
    chk("a_first_nz", f0, 0);
    chk("a_last_nz", l0, 3);
    chk("a_total", tot0, 22);
    chk("a_nbins", nb0, 4);
    chk("a_rv", rv0, 1);
    chk("a_empty", e0, 0);
    chk("a_busy_end", b0, 0);
    idle(2);
    chk("a_rv_hold", rv0, 1);
    chk("a_total_hold", tot0, 22);

    // {0,0,5,0,7,0} with a bubble after every non-final beat
    send(0, 8'd0, 1'b0);
    chk("b_rv_fall", rv0, 0);
    chk("b_old_total_kept", tot0, 22);
    idle(1); chk("b_busy_gap0", b0, 1);
    send(0, 8'd0, 1'b0); idle(1); chk("b_busy_gap1", b0, 1);
    send(0, 8'd5, 1'b0); idle(1); chk("b_busy_gap2", b0, 1);
    send(0, 8'd0, 1'b0); idle(1); chk("b_busy_gap3", b0, 1);
    send(0, 8'd7, 1'b0); idle(1); chk("b_busy_gap4", b0, 1);
    send(0, 8'd0, 1'b1);
    chk("b_peak_idx", pi0, 4);
    chk("b_peak_cnt", pc0, 7);
    chk("b_first_nz", f0, 2);
    chk("b_last_nz", l0, 4);
    chk("b_total", tot0, 12);
    chk("b_nbins", nb0, 6);
    chk("b_busy_end", b0, 0);

    // All-zero 8-bin frame
    for (int i = 0; i < 8; i++) send(0, 8'd0, (i == 7));
    chk("c_empty", e0, 1);
    chk("c_peak_idx", pi0, 0);
    chk("c_peak_cnt", pc0, 0);
    chk("c_first_nz", f0, 0);
    chk("c_last_nz", l0, 0);
    chk("c_total", tot0, 0);
    chk("c_nbins", nb0, 8);

    // Single-beat frame
    send(0, 8'd200, 1'b1);
    chk("d_busy", b0, 0);
    chk("d_rv", rv0, 1);
    chk("d_peak_idx", pi0, 0);
    chk("d_peak_cnt", pc0, 200);
    chk("d_nbins", nb0, 1);
    chk("d_total", tot0, 200);
    chk("d_empty", e0, 0);

    // Clear after 2 beats, asserted together with a valid beat
    send(0, 8'd4, 1'b0);
    send(0, 8'd6, 1'b0);
    clr0 = 1'b1;
    drive(0, 1'b1, 8'd99, 1'b1);
    @(posedge clk); #1;
    clr0 = 1'b0;
    drive(0, 1'b0, 8'd0, 1'b0);
    chk("clr_rv", rv0, 0);
    chk("clr_busy", b0, 0);
    chk("clr_peak_cnt", pc0, 0);
    chk("clr_total", tot0, 0);
    chk("clr_nbins", nb0, 0);
    send(0, 8'd1, 1'b0);
    send(0, 8'd2, 1'b1);
    chk("e_peak_idx", pi0, 1);
    chk("e_peak_cnt", pc0, 2);
    chk("e_total", tot0, 3);
    chk("e_nbins", nb0, 2);
    chk("e_last_nz", l0, 1);
    chk("e_rv", rv0, 1);

    // Asynchronous reset after 2 beats
    send(0, 8'd8, 1'b0);
    send(0, 8'd3, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_rv", rv0, 0);
    chk("rst_peak_cnt", pc0, 0);
    chk("rst_total", tot0, 0);
    chk("rst_busy", b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send(0, 8'd5, 1'b1);
    chk("f_peak_cnt", pc0, 5);
    chk("f_total", tot0, 5);
    chk("f_nbins", nb0, 1);

    // SUM_W = 10: 4 x 255 fits, 5 x 255 clamps at 1023
    for (int i = 0; i < 4; i++) send(1, 8'd255, (i == 3));
    chk("g_total", tot1, 1020);
    chk("g_sat", s1, 0);
    chk("g_nbins", nb1, 4);
    for (int i = 0; i < 5; i++) send(1, 8'd255, (i == 4));
    chk("h_total", tot1, 1023);
    chk("h_sat", s1, 1);
    chk("h_nbins", nb1, 5);
    chk("h_peak_idx", pi1, 0);
    chk("h_peak_cnt", pc1, 255);

    // IDX_W = 2: beats 4 and 5 overflow and are excluded
    send(2, 8'd1, 1'b0);
    send(2, 8'd2, 1'b0);
    send(2, 8'd3, 1'b0);
    send(2, 8'd4, 1'b0);
    send(2, 8'd50, 1'b0);
    chk("i_busy_ovf", b2, 1);
    send(2, 8'd60, 1'b1);
    chk("i_frame_err", fe2, 1);
    chk("i_nbins", nb2, 4);
    chk("i_total", tot2, 10);
    chk("i_peak_idx", pi2, 3);
    chk("i_peak_cnt", pc2, 4);
    chk("i_last_nz", l2, 3);
    chk("i_rv", rv2, 1);
    send(2, 8'd0, 1'b0);
    send(2, 8'd7, 1'b1);
    chk("j_frame_err", fe2, 0);
    chk("j_nbins", nb2, 2);
    chk("j_peak_idx", pi2, 1);
    chk("j_first_nz", f2, 1);
    chk("j_total", tot2, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_peak_finder.md
# hist_peak_finder

Downstream stage of the histogramming core: consumes the bin-count readout stream (one 8-bit count per beat, `valid`, `last` marking the final bin) and reduces each frame to summary statistics. It reports peak bin index and count, first and last non-empty bins, saturating total count and bin count. Results are held in registers until the next frame completes, so a slow host can sample them through the IO pins.

## Interface
Parameters:
- BIN_W, 8, width of one bin count
- IDX_W, 8, bin index width (max 2^IDX_W bins per frame)
- SUM_W, 16, width of saturating total

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bin_data  in  BIN_W  bin count of current beat
- bin_valid  in  1  beat qualifier (no backpressure; every valid beat is accepted)
- bin_last  in  1  final bin of frame, meaningful only with bin_valid
- clear  in  1  synchronous abort: drop frame, zero results, return to IDLE
- peak_idx  out  IDX_W  index of largest bin
- peak_cnt  out  BIN_W  count of largest bin
- first_nz / last_nz  out  IDX_W  lowest / highest index with nonzero count
- empty  out  1  frame had no nonzero bin
- total  out  SUM_W  sum of all counts, saturating
- total_sat  out  1  total saturated
- nbins  out  IDX_W+1  beats accepted in frame
- frame_err  out  1  frame exceeded 2^IDX_W beats
- result_valid  out  1  result registers hold a completed frame
- busy  out  1  frame in progress

## Operation
- States: IDLE, ACCUM, DONE. Reset/clear → IDLE; all outputs 0.
- IDLE/DONE + bin_valid: start frame, beat is index 0; → ACCUM (or straight to DONE if bin_last on same beat).
- ACCUM + bin_valid: index increments; bin_last → DONE.
- Working registers (separate from result registers) track running peak, first/last nonzero, sum, beat count.
- Peak: strictly-greater compare; ties keep lowest index. Empty frame: peak_idx 0, peak_cnt 0, first_nz 0, last_nz 0, empty 1.
- Total: SUM_W adder, clamps at 2^SUM_W-1, total_sat sticky for the frame.
- Overflow: beat arriving when index already 2^IDX_W-1 and not last sets frame_err; further beats ignored (not counted/summed) until bin_last; frame then publishes with frame_err=1.
- Publish: on the bin_last beat all result registers load from working values combined with that beat.
- clear has priority over bin_valid in every state.

## Timing
- Result latency: outputs and result_valid update on the clock edge that samples the bin_last beat (visible the cycle after).
- result_valid stays 1 in DONE; falls on the edge that accepts the first beat of the next frame; result registers keep old values until new publish.
- busy = (state == ACCUM); single-beat frame never raises busy.
- Gaps (bin_valid low) inside a frame are allowed, state held.
- rst_n asserted mid-frame: immediate clear, no partial publish.

## Structure
- Package hist_pkg: state enum (IDLE/ACCUM/DONE), default BIN_W/IDX_W/SUM_W constants, shared with the histogramming core.
- One sub-module: sat_accum (parameterised saturating adder with sticky saturate flag), used for total.
- Top instantiated next to the histogramming core: bin_data←data_out, bin_valid←valid_out, bin_last←last_bin.

## Test plan
- Frame of 4 bins {3,9,9,1}, last on beat 3 → peak_idx 1, peak_cnt 9, first_nz 0, last_nz 3, total 22, nbins 4, result_valid next cycle.
- Frame {0,0,5,0,7,0} with bubbles between beats → peak_idx 4, first_nz 2, last_nz 4, total 12, busy high throughout.
- All-zero 8-bin frame → empty 1, peak_cnt 0, total 0; then single-beat frame {200} with last → peak_idx 0, nbins 1, busy never high.
- SUM_W=10, four bins of 255 → total 1020? no saturation; five bins of 255 → total 1023, total_sat 1.
- IDX_W=2, 6 beats, last on beat 5 → frame_err 1, nbins 4, beats 4-5 excluded from total.
- clear or rst_n mid-frame after 2 beats → outputs zero, result_valid 0; next complete frame reports correctly.
